mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mdu_pkg.sv | 44 ++++
 rtl/mdu_divider.sv | 61 ++++++
 rtl/mult_div_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings, FSM states, result payload and operand helpers for the multiply/divide unit.
package mdu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 5;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
        logic            hw;
        logic            lw;
    } mdu_result_t;

    function automatic logic op_is_mul(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    // Absolute value when the operation treats operands as two's complement.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic sgn);
        return (sgn && x[XLEN-1]) ? XLEN'(-x) : x;
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// Restoring unsigned divider, one quotient bit per step; operands are magnitudes.
module mdu_divider
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    // Shift next dividend bit into the partial remainder and trial-subtract.
    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, dsr_q};
        if (load) begin
            rem_d = '0;
            quo_d = dividend;
            dsr_d = divisor;
        end else if (step) begin
            if (!diff[WIDTH+1]) begin
                rem_d = WIDTH'(diff);
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = WIDTH'(shifted);
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dsr_q <= dsr_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide, MTHI/MTLO moves.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
)
(
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Abort,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HIout,
    output logic [WIDTH-1:0] LOout,
    output logic             HWrite,
    output logic             LWrite
);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               hwr_q, hwr_d;
    logic               lwr_q, lwr_d;

    logic               div_load, div_step;
    logic [WIDTH-1:0]   div_quo, div_rem;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH:0]     mul_sum;
    logic               sgn_op, res_neg, rem_neg;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    mdu_result_t        res;

    mdu_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .load      (div_load),
        .step      (div_step),
        .dividend  (magnitude(A, op_is_signed(Op))),
        .divisor   (magnitude(B, op_is_signed(Op))),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Sign correction: result negative when signs differ, remainder follows the dividend.
    assign sgn_op   = op_is_signed(op_q);
    assign res_neg  = sgn_op && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    assign rem_neg  = sgn_op && a_q[WIDTH-1];
    assign prod_fix = res_neg ? -prod_q : prod_q;
    assign quo_fix  = res_neg ? -div_quo : div_quo;
    assign rem_fix  = rem_neg ? -div_rem : div_rem;
    assign mcand    = magnitude(a_q, sgn_op);
    assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        prod_d   = prod_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hwr_d    = 1'b0;
        lwr_d    = 1'b0;
        div_load = 1'b0;
        div_step = 1'b0;
        res      = '{hi: hi_q, lo: lo_q, hw: 1'b0, lw: 1'b0};

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    op_d     = Op;
                    a_d      = A;
                    b_d      = B;
                    cnt_d    = '0;
                    div_load = op_is_div(Op);
                    if (op_is_mul(Op)) begin
                        prod_d = {{WIDTH{1'b0}}, magnitude(B, op_is_signed(Op))};
                    end
                    state_d = (op_is_mul(Op) || op_is_div(Op)) ? ST_RUN : ST_FINISH;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (op_is_mul(op_q)) begin
                    prod_d = prod_q[0] ? {mul_sum, prod_q[WIDTH-1:1]}
                                       : {1'b0, prod_q[2*WIDTH-1:1]};
                end else begin
                    div_step = 1'b1;
                end
                if (cnt_q == {CNT_W{1'b1}}) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                case (op_q)
                    OP_MULT, OP_MULTU: begin
                        res = '{hi: prod_fix[2*WIDTH-1:WIDTH], lo: prod_fix[WIDTH-1:0],
                                hw: 1'b1, lw: 1'b1};
                    end
                    OP_DIV, OP_DIVU: begin
                        if (b_q == '0) begin
                            res = '{hi: a_q, lo: DIV0_QUOT, hw: 1'b1, lw: 1'b1};
                        end else begin
                            res = '{hi: rem_fix, lo: quo_fix, hw: 1'b1, lw: 1'b1};
                        end
                    end
                    OP_MTHI: res = '{hi: a_q, lo: lo_q, hw: 1'b1, lw: 1'b0};
                    OP_MTLO: res = '{hi: hi_q, lo: a_q, hw: 1'b0, lw: 1'b1};
                    default: res = '{hi: hi_q, lo: lo_q, hw: 1'b0, lw: 1'b0};
                endcase
                hi_d  = res.hi;
                lo_d  = res.lo;
                hwr_d = res.hw;
                lwr_d = res.lw;
            end
            default: state_d = ST_IDLE;
        endcase

        // Flush wins over everything, including a same-cycle Start.
        if (Abort) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            done_d   = 1'b0;
            hi_d     = hi_q;
            lo_d     = lo_q;
            hwr_d    = 1'b0;
            lwr_d    = 1'b0;
            div_load = 1'b0;
            div_step = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            hwr_q   <= 1'b0;
            lwr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hwr_q   <= hwr_d;
            lwr_q   <= lwr_d;
        end
    end

    assign Busy   = busy_q;
    assign Done   = done_q;
    assign HIout  = hi_q;
    assign LOout  = lo_q;
    assign HWrite = hwr_q;
    assign LWrite = lwr_q;

endmodule
